// File: rtl/serial_argmax_signed.sv
// serial_argmax_signed: streaming signed argmax over a valid/ready input stream.
// Each frame is NUM_INPUTS elements long. After the last element of a frame,
// the block holds the maximum and its beat index on a valid/ready output
// until the consumer accepts them. Ties resolve to the highest index.
module serial_argmax_signed #(
   parameter int WIDTH      = 5,
   parameter int NUM_INPUTS = 16,
   localparam int IDX_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH-1:0]     in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [WIDTH-1:0]     max,
   output logic        [IDX_WIDTH-1:0] argmax
);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] HOLD    = 1'b1;

   // NUM_INPUTS need not be a power of two, so the last beat is an explicit compare
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

   logic [0:0]           state;
   logic [IDX_WIDTH-1:0] count;

   // Handshake outputs are decoded from the state register only
   assign in_ready  = (state == COLLECT);
   assign out_valid = (state == HOLD);

   // Frame collection, running signed maximum and result hand-off
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= COLLECT;
         count  <= '0;
         max    <= '0;
         argmax <= '0;
      end else if (state == COLLECT) begin
         if (in_valid) begin
            // First beat overwrites the previous frame's result; later beats
            // take over on >= so equal values move argmax to the newer index.
            if (count == '0) begin
               max    <= in_data;
               argmax <= '0;
            end else if (in_data >= max) begin
               max    <= in_data;
               argmax <= count;
            end
            if (count == LAST_IDX) begin
               count <= '0;
               state <= HOLD;
            end else begin
               count <= count + 1'b1;
            end
         end
      end else begin
         if (out_ready) begin
            state <= COLLECT;
         end
      end
   end

endmodule

// File: tb/tb_serial_argmax_signed.sv
// Scoreboard bench for serial_argmax_signed: the driver records every accepted
// beat in a reference model and pushes each completed frame's expected result;
// a monitor compares whatever the DUT presents on its output stream.
module tb_serial_argmax_signed;

   localparam int WIDTH      = 5;
   localparam int NUM_INPUTS = 16;
   localparam int IDX_WIDTH  = $clog2(NUM_INPUTS);

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        in_valid;
   logic                        in_ready;
   logic signed [WIDTH-1:0]     in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [WIDTH-1:0]     max_o;
   logic        [IDX_WIDTH-1:0] argmax_o;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit rand_ordy = 1'b0;

   typedef struct { int mx; int idx; } res_t;
   res_t exp_q[$];
   int   beats[$];

   serial_argmax_signed #(.WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .max(max_o), .argmax(argmax_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: largest value of the frame, then the last position holding it
   function automatic res_t ref_frame(input int v[$]);
      res_t r;
      r.mx = v[0];
      foreach (v[i]) if (v[i] > r.mx) r.mx = v[i];
      r.idx = 0;
      foreach (v[i]) if (v[i] == r.mx) r.idx = i;
      return r;
   endfunction

   // Offer one element; returns once it has been accepted (or the bound expires)
   task automatic send_beat(input int v, output int acc);
      int n = 0;
      acc = -1;
      in_valid = 1'b1;
      in_data  = WIDTH'(v);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("beat_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      acc = cyc;
      @(posedge clk);
      beats.push_back(v);
      if (beats.size() == NUM_INPUTS) begin
         exp_q.push_back(ref_frame(beats));
         beats.delete();
      end
      #1;
   endtask

   task automatic send_frame(input int v[$], input int max_gap);
      int acc;
      foreach (v[i]) begin
         send_beat(v[i], acc);
         if (max_gap > 0) begin
            int g = $urandom_range(0, max_gap);
            if (g > 0) begin
               in_valid = 1'b0;
               repeat (g) @(posedge clk);
               #1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   // Monitor: result must match the queue head on every cycle it is presented
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("in_ready_vs_out_valid", int'(in_ready), int'(!out_valid));
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 1, 0);
               end else begin
                  chk("max", int'(max_o), exp_q[0].mx);
                  chk("argmax", int'(argmax_o), exp_q[0].idx);
                  if (out_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Random back-pressure on the output stream when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int f[$];
      int acc_a, acc_b, acc;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_max", int'(max_o), 0);
      chk("reset_argmax", int'(argmax_o), 0);
      @(posedge clk); #1;

      // Descending frame, back-to-back, with latency check
      f = {15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0};
      send_frame(f, 0);
      @(negedge clk);
      chk("latency_out_valid", int'(out_valid), 1);
      chk("latency_in_ready", int'(in_ready), 0);
      @(negedge clk);
      chk("release_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // All-equal frames: zeros then most-negative value
      f = {}; repeat (NUM_INPUTS) f.push_back(0);
      send_frame(f, 0);
      f = {}; repeat (NUM_INPUTS) f.push_back(-16);
      send_frame(f, 0);

      // Mixed frame with random gaps
      f = {-12,2,11,9,8,-14,-8,-13,-1,8,-2,-1,4,-4,9,-10};
      send_frame(f, 3);

      // Held result under back-pressure; in_valid during HOLD is not consumed
      repeat (3) @(posedge clk); #1;
      out_ready = 1'b0;
      f = {-2,9,6,6,13,1,-16,8,-8,-3,11,-13,14,7,-4,10};
      send_frame(f, 0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 5'sd7;
         @(negedge clk);
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", int'(out_valid), 1);
      @(negedge clk);
      chk("hold_release_ready", int'(in_ready), 1);
      @(posedge clk); #1;

      // Partial frame discarded by reset (asserted alongside in_valid)
      for (int i = 0; i < 7; i++) send_beat(13, acc);
      rst = 1'b1; in_valid = 1'b1; in_data = 5'sd13;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      beats.delete(); exp_q.delete();
      @(negedge clk);
      chk("midframe_reset_max", int'(max_o), 0);
      chk("midframe_reset_argmax", int'(argmax_o), 0);
      chk("midframe_reset_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      f = {-15,12,-16,1,-1,1,-9,-5,6,2,-12,-6,-6,0,-6,1};
      send_frame(f, 0);

      // Two consecutive random frames, continuous in_valid: minimum frame period
      repeat (2) @(posedge clk); #1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         send_beat($urandom_range(0, 31) - 16, acc);
         if (i == 0) acc_a = acc;
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
         send_beat($urandom_range(0, 31) - 16, acc);
         if (i == 0) acc_b = acc;
      end
      in_valid = 1'b0;
      chk("frame_period", acc_b - acc_a, NUM_INPUTS + 1);

      // Random frames with random gaps and random output back-pressure
      rand_ordy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         f = {};
         repeat (NUM_INPUTS) f.push_back($urandom_range(0, 31) - 16);
         send_frame(f, 2);
      end
      rand_ordy = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk); @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_argmax_signed.md
Name: serial_argmax_signed

Overview:
- Streaming counterpart to the team's parallel signed argmax.
- Consumes one signed element per accepted beat over a valid/ready input stream.
- After NUM_INPUTS beats, presents the frame's maximum and its index on a valid/ready output stream.
- Used where inputs arrive serially from a producer, e.g. a classifier output scan, instead of as a parallel array.

Parameters:
- WIDTH, 5, bit width of each signed element and of max.
- NUM_INPUTS, 16, elements per frame; must be >= 2.
- IDX_WIDTH (localparam), $clog2(NUM_INPUTS), width of argmax and of the beat counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  block can accept an element.
- in_data  input  WIDTH  signed element, two's complement.
- out_valid  output  1  max/argmax hold a completed frame result.
- out_ready  input  1  consumer accepts the result.
- max  output  WIDTH  signed maximum of the frame.
- argmax  output  IDX_WIDTH  index (beat position 0..NUM_INPUTS-1) of max.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
  - in_ready and out_valid are decoded from the state register only; no combinational path from out_ready or in_valid.
- Reset: state=COLLECT, count=0, max=0, argmax=0, out_valid=0, in_ready=1. Any partial frame is discarded. Reset has priority over all handshakes in the same cycle.
- Input beat accepted when in_valid && in_ready at the clock edge. Cycles with in_valid=0 leave all state unchanged; gaps are allowed anywhere in a frame.
- On accepted beat with count==0: max<=in_data, argmax<=0. The previous result is overwritten unconditionally.
- On accepted beat with count==k>0: if $signed(in_data) >= $signed(max), then max<=in_data and argmax<=k.
  - Ties resolve to the highest index, matching the parallel argmax (all-equal frame gives argmax=NUM_INPUTS-1).
  - Comparison is full signed WIDTH-bit; no saturation or extension.
- count increments per accepted beat. On the beat with count==NUM_INPUTS-1: count<=0, state<=HOLD.
- Latency: out_valid rises on the cycle after the last beat is accepted. max/argmax already include that beat.
- HOLD: max/argmax/out_valid stable while out_ready=0, for any duration. When out_valid && out_ready, state<=COLLECT the next cycle; in_ready returns to 1 then.
- Input is blocked in HOLD (in_ready=0). in_valid asserted in HOLD is ignored and the element is not consumed.
- Minimum frame period: NUM_INPUTS+1 cycles (NUM_INPUTS beats plus one HOLD cycle with out_ready=1).
- max/argmax keep their last values in COLLECT until the first beat of the next frame. They are only meaningful while out_valid=1.
- No overflow conditions: count never exceeds NUM_INPUTS-1.
- NUM_INPUTS need not be a power of two; count compares against NUM_INPUTS-1 explicitly.

Test Plan:
- Reset, then 16 back-to-back beats 15,14,...,0 with out_ready=1 -> out_valid one cycle after the last beat, max=15, argmax=0; in_ready=0 that cycle, 1 the next.
- 16 zeros -> max=0, argmax=15. Then 16 beats of -16 -> max=-16, argmax=15 (tie rule, most-negative value).
- Frame -12,2,11,9,8,-14,-8,-13,-1,8,-2,-1,4,-4,9,-10 with random in_valid gaps -> max=11, argmax=2.
- Frame -2,9,6,6,13,1,-16,8,-8,-3,11,-13,14,7,-4,10, out_ready held low 5 cycles -> out_valid, max=14, argmax=12 stable throughout; in_ready=0 and in_valid beats during HOLD not consumed; release -> in_ready=1 next cycle.
- Accept 7 beats of 13, assert rst for one cycle (with in_valid=1), then frame -15,12,-16,1,-1,1,-9,-5,6,2,-12,-6,-6,0,-6,1 -> max=12, argmax=1. Partial frame discarded; exactly 16 beats needed post-reset.
- Two consecutive frames with out_ready=1 continuously -> second frame's first beat accepted exactly NUM_INPUTS+1 cycles after the first frame's first beat; results independent of the prior frame.
